// File: rtl/masker_pkg.sv
// Shared constants, FSM encoding and the single-step Galois LFSR function
// used by the share encoder and its mask source.
package masker_pkg;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } fsm_t;

    // One right-shifting Galois step of x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/mask_lfsr.sv
// Reseedable 32-bit Galois LFSR; each advance moves the state three steps so
// that the three mask bits of consecutive draws never overlap.
module mask_lfsr
    import masker_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] state
);

    logic [31:0] state_reg;
    logic [31:0] chain [0:3];

    assign chain[0] = state_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_step
            assign chain[gi+1] = lfsr_step(chain[gi]);
        end
    endgenerate

    // A load always overrides an advance in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SEED;
        end else if (load) begin
            state_reg <= load_value;
        end else if (advance) begin
            state_reg <= chain[3];
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/share_masker.sv
// First-order Boolean share encoder for the masked half adder: splits A and B
// into two shares each, adds a refresh bit, and presents them through a
// one-entry valid/ready output register.
module share_masker
    import masker_pkg::*;
#(
    parameter int          LFSR_W        = 32,
    parameter logic [31:0] SEED          = DEFAULT_SEED,
    parameter int          WARMUP_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              A,
    input  logic              B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              A0,
    output logic              A1,
    output logic              B0,
    output logic              B1,
    output logic              rN,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed_data
);

    localparam logic [7:0] WARMUP_LAST = 8'(WARMUP_CYCLES - 1);

    fsm_t        state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        ready_c;
    logic        advance;
    logic        accept;
    logic [31:0] lfsr_state;
    logic [31:0] load_value;

    logic        out_valid_reg;
    logic        a0_reg, a1_reg, b0_reg, b1_reg, rn_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready_c    = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            WARMUP: begin
                advance = 1'b1;
                if (cnt_reg == WARMUP_LAST) begin
                    state_next = RUN;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            RUN: begin
                ready_c = !seed_valid && (!out_valid_reg || out_ready);
                advance = in_valid && ready_c;
            end
            default: begin
                state_next = WARMUP;
                cnt_next   = 8'd0;
            end
        endcase
        // Reseed beats everything, including a handshake in the same cycle.
        if (seed_valid) begin
            state_next = WARMUP;
            cnt_next   = 8'd0;
            advance    = 1'b0;
        end
    end

    assign accept     = in_valid && ready_c;
    assign load_value = (seed_data == '0) ? SEED : 32'(seed_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= WARMUP;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    mask_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance),
        .load      (seed_valid),
        .load_value(load_value),
        .state     (lfsr_state)
    );

    // Plaintext only ever reaches the register file XORed with a fresh mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            a0_reg        <= 1'b0;
            a1_reg        <= 1'b0;
            b0_reg        <= 1'b0;
            b1_reg        <= 1'b0;
            rn_reg        <= 1'b0;
        end else if (seed_valid) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            a0_reg        <= A ^ lfsr_state[0];
            a1_reg        <= lfsr_state[0];
            b0_reg        <= B ^ lfsr_state[1];
            b1_reg        <= lfsr_state[1];
            rn_reg        <= lfsr_state[2];
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign in_ready  = ready_c;
    assign out_valid = out_valid_reg;
    assign A0        = a0_reg;
    assign A1        = a1_reg;
    assign B0        = b0_reg;
    assign B1        = b1_reg;
    assign rN        = rn_reg;

endmodule

// File: tb/tb_share_masker.sv
// Directed-sequence bench for share_masker with random operands, checked
// against a software LFSR stream model.
module tb_share_masker;

    localparam logic [31:0] TB_SEED = 32'hACE1_2468;
    localparam logic [31:0] TB_TAPS = 32'h8020_0003;
    localparam int          WARM    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        A = 1'b0;
    logic        B = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        A0, A1, B0, B1, rN;
    logic        seed_valid = 1'b0;
    logic [31:0] seed_data = 32'd0;

    int          checks = 0;
    int          errors = 0;
    int          ones_a1 = 0;
    logic [31:0] m_lfsr;
    logic        ea0, ea1, eb0, eb1, er;
    logic [2:0]  rec [0:15];

    share_masker #(
        .LFSR_W       (32),
        .SEED         (TB_SEED),
        .WARMUP_CYCLES(WARM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A0        (A0),
        .A1        (A1),
        .B0        (B0),
        .B1        (B1),
        .rN        (rN),
        .seed_valid(seed_valid),
        .seed_data (seed_data)
    );

    always #5 clk = ~clk;

    // Model: one draw consumes three Galois steps of the polynomial.
    function automatic logic [31:0] model_adv(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        for (int k = 0; k < 3; k++) begin
            if (y[0]) y = (y >> 1) ^ TB_TAPS;
            else      y = y >> 1;
        end
        return y;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Warm-up window: in_ready low and no output for WARM cycles.
    task automatic warm();
        for (int k = 0; k < WARM; k++) begin
            #1;
            check("warm_in_ready", 32'(in_ready), 32'd0);
            check("warm_out_valid", 32'(out_valid), 32'd0);
            m_lfsr = model_adv(m_lfsr);
            tick();
        end
    endtask

    task automatic run_set(input bit do_rec, input bit do_cmp, input int idx, input bit count);
        logic a, b;
        a = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("run_in_ready", 32'(in_ready), 32'd1);
        ea0 = a ^ m_lfsr[0]; ea1 = m_lfsr[0];
        eb0 = b ^ m_lfsr[1]; eb1 = m_lfsr[1];
        er  = m_lfsr[2];
        m_lfsr = model_adv(m_lfsr);
        tick();
        check("set_out_valid", 32'(out_valid), 32'd1);
        check("set_shares", {27'd0, A0, A1, B0, B1, rN}, {27'd0, ea0, ea1, eb0, eb1, er});
        check("set_unmask_a", 32'(A0 ^ A1), 32'(a));
        check("set_unmask_b", 32'(B0 ^ B1), 32'(b));
        if (count) ones_a1 += int'(A1);
        if (do_rec) rec[idx] = {ea1, eb1, er};
        if (do_cmp) check("replay_masks", {29'd0, A1, B1, rN}, {29'd0, rec[idx]});
    endtask

    initial begin
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_shares", {27'd0, A0, A1, B0, B1, rN}, 32'd0);
        rst = 1'b0;
        m_lfsr = TB_SEED;
        warm();

        // Main stream: one set per cycle.
        for (int i = 0; i < 1000; i++) run_set(i < 16, 1'b0, i % 16, 1'b1);
        $display("stream: A1 ones=%0d of 1000", ones_a1);
        check("a1_balance", 32'((ones_a1 >= 450) && (ones_a1 <= 550)), 32'd1);

        // Backpressure: held outputs, no accept, LFSR frozen.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A = 1'($urandom_range(0, 1)); B = 1'($urandom_range(0, 1));
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_shares", {27'd0, A0, A1, B0, B1, rN}, {27'd0, ea0, ea1, eb0, eb1, er});
        end
        run_set(1'b0, 1'b0, 0, 1'b0);

        // Reseed to 1 with a pending set under backpressure.
        out_ready = 1'b0; seed_valid = 1'b1; seed_data = 32'h0000_0001;
        #1;
        check("reseed_in_ready", 32'(in_ready), 32'd0);
        tick();
        seed_valid = 1'b0;
        check("reseed_drop_valid", 32'(out_valid), 32'd0);
        check("reseed_lfsr", dut.lfsr_state, 32'h0000_0001);
        m_lfsr = 32'h0000_0001;
        warm();
        for (int i = 0; i < 20; i++) run_set(1'b0, 1'b0, 0, 1'b0);

        // Zero seed maps to the reset seed and replays the post-reset stream.
        seed_valid = 1'b1; seed_data = 32'd0;
        tick();
        seed_valid = 1'b0;
        check("reseed0_lfsr", dut.lfsr_state, TB_SEED);
        m_lfsr = TB_SEED;
        warm();
        for (int i = 0; i < 16; i++) run_set(1'b0, 1'b1, i, 1'b0);

        // Asynchronous reset between edges mid-stream.
        for (int i = 0; i < 4; i++) run_set(1'b0, 1'b0, 0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_shares", {27'd0, A0, A1, B0, B1, rN}, 32'd0);
        check("arst_lfsr", dut.lfsr_state, TB_SEED);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        m_lfsr = TB_SEED;
        warm();
        for (int i = 0; i < 10; i++) run_set(1'b0, 1'b1, i, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/share_masker.md
# share_masker

First-order share encoder that sits directly upstream of the masked half adder. It takes plaintext operand bits A and B and splits each into two Boolean shares. It also supplies the fresh refresh bit rN, drawing all randomness from an internal reseedable LFSR. Output goes out through a one-entry valid/ready register, so the adder stage sees one fully masked operand set per transfer.

## Interface
Parameters:
- LFSR_W, 32: LFSR state width. Fixed at 32 for the polynomial below.
- SEED, 32'hACE1_2468: reset seed, and the substitute used when a zero seed is loaded.
- WARMUP_CYCLES, 8: LFSR advance cycles after reset or reseed before input is accepted. Range 1..255.

Ports:
- clk, input, 1: sole clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: A/B are valid.
- in_ready, output, 1: block accepts A/B this cycle.
- A, input, 1: plaintext operand A.
- B, input, 1: plaintext operand B.
- out_valid, output, 1: share outputs hold a masked operand set.
- out_ready, input, 1: downstream consumes the current set.
- A0, output, 1: share 0 of A.
- A1, output, 1: share 1 of A.
- B0, output, 1: share 0 of B.
- B1, output, 1: share 1 of B.
- rN, output, 1: fresh refresh bit for the masked AND.
- seed_valid, input, 1: single-cycle reseed request.
- seed_data, input, LFSR_W: new LFSR seed.

## Operation
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, tap mask 32'h8020_0003.
  - Shift right; if the LFSR LSB was 1, XOR the tap mask.
  - Every "advance" is exactly 3 single steps, unrolled combinationally.
- Random bits are taken from the current LFSR state before the advance: mA = lfsr[0], mB = lfsr[1], r = lfsr[2].
- Encoding on accept: A0 = A^mA, A1 = mA, B0 = B^mB, B1 = mB, rN = r. All five are registered together with out_valid.
- FSM states:
  - WARMUP: LFSR advances every cycle and a counter counts up. in_ready = 0. Leave for RUN when the counter reaches WARMUP_CYCLES-1.
  - RUN: in_ready = !seed_valid && (!out_valid || out_ready). The LFSR advances only on accept (in_valid && in_ready); otherwise it holds.
- Reseed (seed_valid = 1, any state), applied at the next edge:
  - lfsr <= (seed_data == 0) ? SEED : seed_data.
  - Counter cleared, state <= WARMUP, out_valid <= 0 (any pending set is discarded).
  - If out_valid && out_ready in that same cycle, that transfer counts as completed.
- Plaintext A/B never appears in any register. Only shares and LFSR state are stored.
- Reset values: state WARMUP, counter 0, lfsr SEED, out_valid 0, A0/A1/B0/B1/rN all 0. in_ready is 0 during reset.

## Timing
- Latency: accept at edge N means out_valid = 1 with the shares from cycle N+1.
- Throughput: one set per cycle when out_ready is held high. The output register is then refilled on the same edge it drains.
- Backpressure: while out_valid && !out_ready, all share outputs and the LFSR hold stable.
- After rst deasserts, in_ready first rises on cycle WARMUP_CYCLES. The same applies after a reseed edge.
- seed_valid forces in_ready low combinationally in the same cycle. Reseed wins over a simultaneous input handshake; that input is not accepted.
- A rst assertion mid-transfer clears out_valid asynchronously. No partial set is ever emitted.

## Structure
- Package masker_pkg holds:
  - LFSR_TAPS (32'h8020_0003).
  - Default SEED constant.
  - FSM enum {WARMUP, RUN}.
  - Pure function lfsr_step(state) returning one Galois step.
- Sub-module mask_lfsr:
  - Holds the state register with async reset to SEED.
  - Inputs: advance and load/load_value.
  - Output: current state. Applies the 3-step advance internally.
- The top-level holds the FSM, warm-up counter, output register and handshake logic.

## Test plan
- Reset release with in_valid held at 1, WARMUP_CYCLES=8 -> in_ready = 0 for cycles 0..7, first accept on cycle 8. out_valid = 0 throughout warm-up.
- 1000 random A/B with out_ready = 1 -> one set per cycle. Each set satisfies A0^A1 == A and B0^B1 == B. mA/mB/rN match a golden LFSR model exactly; the ones-fraction of A1 lies in 0.45..0.55.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 -> outputs and LFSR unchanged, in_ready = 0. On release, the next set uses the model's next 3-step state.
- Reseed seed_data = 32'h0000_0001 mid-stream with out_valid = 1, out_ready = 0 -> out_valid = 0 next cycle, 8 warm-up cycles, then shares match the model seeded with 1.
- Reseed seed_data = 0 -> LFSR equals SEED after the load, and the stream matches the post-reset stream bit-for-bit.
- Async rst pulse between clock edges during a stream -> out_valid and all shares read 0 immediately, and the LFSR returns to SEED.
